// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I execute-stage constants (ALU ops, forwarding selects, branch funct3)
package riscv_pkg;
  localparam int XLEN = 32;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX inputs, PC redirect and EX/MEM outputs of the execute stage
interface ex_stage_if #(parameter int XLEN = riscv_pkg::XLEN);
  logic            in_valid, stall, flush;
  logic [3:0]      alu_ctrl;
  logic [2:0]      funct3;
  logic            is_branch, is_jal, is_jalr;
  logic            alu_src_a, alu_src_b;
  logic [1:0]      fwd_a, fwd_b;
  logic [XLEN-1:0] rs1_data, rs2_data, imm, pc;
  logic [XLEN-1:0] fwd_mem_data, fwd_wb_data;
  logic [4:0]      rd;
  logic            reg_write, mem_write, mem_read;
  logic [1:0]      result_src;
  logic            redirect;
  logic [XLEN-1:0] redirect_target;
  logic            exm_valid, exm_reg_write, exm_mem_write, exm_mem_read;
  logic [XLEN-1:0] exm_result, exm_store_data, exm_pc_plus4;
  logic [4:0]      exm_rd;
  logic [1:0]      exm_result_src;
  modport master (
    output in_valid, stall, flush, alu_ctrl, funct3, is_branch, is_jal, is_jalr,
           alu_src_a, alu_src_b, fwd_a, fwd_b, rs1_data, rs2_data, imm, pc,
           fwd_mem_data, fwd_wb_data, rd, reg_write, mem_write, mem_read, result_src,
    input  redirect, redirect_target, exm_valid, exm_reg_write, exm_mem_write,
           exm_mem_read, exm_result, exm_store_data, exm_pc_plus4, exm_rd, exm_result_src
  );
  modport slave (
    input  in_valid, stall, flush, alu_ctrl, funct3, is_branch, is_jal, is_jalr,
           alu_src_a, alu_src_b, fwd_a, fwd_b, rs1_data, rs2_data, imm, pc,
           fwd_mem_data, fwd_wb_data, rd, reg_write, mem_write, mem_read, result_src,
    output redirect, redirect_target, exm_valid, exm_reg_write, exm_mem_write,
           exm_mem_read, exm_result, exm_store_data, exm_pc_plus4, exm_rd, exm_result_src
  );
endinterface

// File: rtl/ex_stage_alu_core.sv
// alu_core: purely combinational RV32I integer ALU
module alu_core import riscv_pkg::*; #(
  parameter int W = XLEN
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   alu_ctrl,
  output logic [W-1:0] y
);
  // operation select; undefined codes yield zero
  always_comb begin
    y = '0;
    case (alu_ctrl)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_SLL:  y = a << b[4:0];
      ALU_SRL:  y = a >> b[4:0];
      ALU_SRA:  y = W'($signed(a) >>> b[4:0]);
      ALU_SLT:  y = W'($signed(a) < $signed(b));
      ALU_SLTU: y = W'(a < b);
      default:  y = '0;
    endcase
  end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: RV32I execute stage with forwarding, branch resolution and EX/MEM register
module ex_stage #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input logic       clk,
  input logic       rst,
  ex_stage_if.slave bus
);
  import riscv_pkg::*;
  logic [XLEN-1:0] fa, fb, op_a, op_b, alu_y;
  logic cond;
  assign fa = bus.fwd_a == FWD_WB ? bus.fwd_wb_data : bus.fwd_a == FWD_MEM ? bus.fwd_mem_data : bus.rs1_data;
  assign fb = bus.fwd_b == FWD_WB ? bus.fwd_wb_data : bus.fwd_b == FWD_MEM ? bus.fwd_mem_data : bus.rs2_data;
  assign op_a = bus.alu_src_a ? bus.pc : fa;
  assign op_b = bus.alu_src_b ? bus.imm : fb;
  alu_core #(.W(XLEN)) u_alu (.a(op_a), .b(op_b), .alu_ctrl(bus.alu_ctrl), .y(alu_y));
  // branch comparator; funct3 010/011 never taken
  always_comb begin
    cond = 1'b0;
    case (bus.funct3)
      F3_BEQ:  cond = fa == fb;
      F3_BNE:  cond = fa != fb;
      F3_BLT:  cond = $signed(fa) < $signed(fb);
      F3_BGE:  cond = $signed(fa) >= $signed(fb);
      F3_BLTU: cond = fa < fb;
      F3_BGEU: cond = fa >= fb;
      default: cond = 1'b0;
    endcase
  end
  // stalled instructions do not redirect, so a held jump fires once on release
  assign bus.redirect = bus.in_valid & ~bus.stall & (bus.is_jal | bus.is_jalr | (bus.is_branch & cond));
  assign bus.redirect_target = bus.is_jalr ? (fa + bus.imm) & ~XLEN'(1) : bus.pc + bus.imm;
  // EX/MEM register: reset > flush (kill controls, hold data) > stall (hold) > capture
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.exm_valid      <= 1'b0;
      bus.exm_reg_write  <= 1'b0;
      bus.exm_mem_write  <= 1'b0;
      bus.exm_mem_read   <= 1'b0;
      bus.exm_result     <= '0;
      bus.exm_store_data <= '0;
      bus.exm_pc_plus4   <= '0;
      bus.exm_rd         <= '0;
      bus.exm_result_src <= '0;
    end else if (bus.flush) begin
      bus.exm_valid      <= 1'b0;
      bus.exm_reg_write  <= 1'b0;
      bus.exm_mem_write  <= 1'b0;
      bus.exm_mem_read   <= 1'b0;
    end else if (!bus.stall) begin
      bus.exm_valid      <= bus.in_valid;
      bus.exm_reg_write  <= bus.reg_write & bus.in_valid;
      bus.exm_mem_write  <= bus.mem_write & bus.in_valid;
      bus.exm_mem_read   <= bus.mem_read & bus.in_valid;
      bus.exm_result     <= alu_y;
      bus.exm_store_data <= fb;
      bus.exm_pc_plus4   <= bus.pc + XLEN'(4);
      bus.exm_rd         <= bus.rd;
      bus.exm_result_src <= bus.result_src;
    end
  end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RV32I pipeline.
- Consumes the 4-bit ALU control code produced by the ALU-control decoder, plus ID/EX operands and control bits.
- Applies forwarding muxes, computes the ALU result, resolves branches and jumps, and registers the results into the EX/MEM pipeline register.
- Drives the PC redirect (combinational) and the EX/MEM outputs (1-cycle latency) toward the memory stage.

Parameters:
- XLEN, 32, datapath width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  ID/EX holds a valid instruction
- stall  in  1  hold EX/MEM contents (memory-side backpressure)
- flush  in  1  squash the instruction entering EX/MEM this cycle
- alu_ctrl  in  4  ALU operation code
- funct3  in  3  branch condition select
- is_branch / is_jal / is_jalr  in  1 each  control-flow type
- alu_src_a  in  1  0 = rs1, 1 = pc (AUIPC)
- alu_src_b  in  1  0 = rs2, 1 = imm
- fwd_a, fwd_b  in  2 each  00 = regfile, 01 = WB data, 10 = MEM data, 11 = regfile
- rs1_data, rs2_data, imm, pc  in  XLEN each  operands
- fwd_mem_data, fwd_wb_data  in  XLEN each  forwarded values
- rd  in  5  destination register
- reg_write, mem_write, mem_read  in  1 each  downstream control
- result_src  in  2  writeback select, passed through
- redirect  out  1  take PC target (combinational)
- redirect_target  out  XLEN  new PC (combinational)
- exm_valid, exm_reg_write, exm_mem_write, exm_mem_read  out  1 each  registered
- exm_result, exm_store_data, exm_pc_plus4  out  XLEN each  registered
- exm_rd  out  5; exm_result_src  out  2  registered

Behaviour:
- Reset: rst high at a clock edge sets all exm_* outputs to 0.
- Forwarding: fa/fb are the forwarded rs1/rs2 selected per the fwd codes.
- ALU operands: A = alu_src_a ? pc : fa; B = alu_src_b ? imm : fb.
- ALU codes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA; shift amount is B[4:0].
  - 1000 SLT (signed), 1001 SLTU; result is zero-extended 0/1.
  - Any other code gives result 0.
- All arithmetic is modulo 2^XLEN; overflow is ignored.
- Branch condition uses fa vs fb per funct3:
  - 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU.
  - 010 and 011 are never taken.
- redirect = in_valid & ~stall & (is_jal | is_jalr | (is_branch & cond)).
- redirect_target:
  - JALR: (fa + imm) with bit0 cleared.
  - Otherwise: pc + imm.
- Latency: one clock from ID/EX inputs to exm_* outputs.
- Per-edge priority on the EX/MEM register:
  1. rst: clear all.
  2. flush: exm_valid, exm_reg_write, exm_mem_write, exm_mem_read all go to 0; datapath fields are don't-care (implement as hold). Flush beats stall.
  3. stall: all exm_* hold their values.
  4. Otherwise: capture.
- Capture values:
  - exm_valid = in_valid.
  - Control bits are ANDed with in_valid.
  - exm_result = ALU result.
  - exm_store_data = fb.
  - exm_pc_plus4 = pc + 4.
  - exm_rd = rd.
- rd = 0: passed through unchanged; regfile ignores x0 writes.
- Redirect is suppressed while stall is high, so a stalled jump redirects only once, on its release cycle.
- Reset mid-stall: reset wins and the outputs clear.
- pc + imm wraps modulo 2^XLEN.

Decomposition:
- Shared package riscv_pkg holds:
  - ALU op constants (ALU_ADD..ALU_SLTU).
  - Forward-select constants (FWD_RF, FWD_WB, FWD_MEM).
  - Branch funct3 constants.
  - XLEN default.
- One sub-module, alu_core: a purely combinational A/B/alu_ctrl -> result block, reusable by any future second ALU.
- The branch comparator and EX/MEM register stay in ex_stage.

Test Plan:
- SUB with forwarding: fwd_a=10, fwd_mem_data=0x10, rs2=0x3, alu_ctrl=0001, in_valid=1 -> next cycle exm_result=0x0000000D, exm_valid=1.
- SRA/SLT signed: A=0x80000000, imm=4, alu_src_b=1, alu_ctrl=0111 -> exm_result=0xF8000000; alu_ctrl=1000, A=0xFFFFFFFF, B=1 -> 1; alu_ctrl=1001 -> 0.
- BLT taken: is_branch=1, funct3=100, fa=0xFFFFFFFE, fb=1, pc=0x100, imm=0x20 -> redirect=1, target=0x120 in the same cycle; funct3=110 with the same operands -> redirect=0.
- JALR: fa=0x1003, imm=0x4, is_jalr=1, pc=0x200 -> target=0x1006 (bit0 cleared), exm_pc_plus4=0x204.
- Stall then flush: capture ADD, assert stall 3 cycles -> exm_* stable and redirect=0; stall+flush together -> exm_valid=0, exm_reg_write=0 next edge.
- Reset mid-operation: rst=1 while exm_valid=1 and stall=1 -> all exm_* = 0 after the edge; in_valid=0 with reg_write=1 -> exm_reg_write=0.
